// File: rtl/karatsuba_pkg.sv
// Shared types, widths and phase encoding for the Karatsuba 32x32 sequencer.
package karatsuba_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;
  localparam int PROD_W = 64;

  localparam logic [1:0] PH_LO  = 2'd0;
  localparam logic [1:0] PH_HI  = 2'd1;
  localparam logic [1:0] PH_MID = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    REL,
    COMB,
    DONE
  } kseq_state_t;

  // Returns {m_a, m_b} for a given phase.
  function automatic logic [FULL_W-1:0] phase_operands(
    input logic [1:0]        ph,
    input logic [FULL_W-1:0] a,
    input logic [FULL_W-1:0] b,
    input logic [HALF_W-1:0] sa_lo,
    input logic [HALF_W-1:0] sb_lo
  );
    case (ph)
      PH_HI:   return {a[FULL_W-1:HALF_W], b[FULL_W-1:HALF_W]};
      PH_MID:  return {sa_lo, sb_lo};
      default: return {a[HALF_W-1:0], b[HALF_W-1:0]};
    endcase
  endfunction

endpackage

// File: rtl/karatsuba32_seq_if.sv
// Requester-side and mult16-side level-held start/done handshakes.
interface karatsuba32_seq_if;
  import karatsuba_pkg::*;

  logic                start;
  logic [FULL_W-1:0]   A;
  logic [FULL_W-1:0]   B;
  logic                done;
  logic [PROD_W-1:0]   P;

  modport master (output start, A, B, input done, P);
  modport slave  (input start, A, B, output done, P);
endinterface

interface mult16_if;
  import karatsuba_pkg::*;

  logic                m_start;
  logic [HALF_W-1:0]   m_a;
  logic [HALF_W-1:0]   m_b;
  logic                m_done;
  logic [FULL_W-1:0]   m_p;

  modport master (output m_start, m_a, m_b, input m_done, m_p);
  modport slave  (input m_start, m_a, m_b, output m_done, m_p);
endinterface

// File: rtl/karatsuba_combine.sv
// Combines the three 16x16 partial products into the 64-bit Karatsuba result.
module karatsuba_combine
  import karatsuba_pkg::*;
(
  input  logic [FULL_W-1:0] z0_i,
  input  logic [FULL_W-1:0] z2_i,
  input  logic [FULL_W-1:0] pm_i,
  input  logic [HALF_W:0]   sa_i,
  input  logic [HALF_W:0]   sb_i,
  output logic [PROD_W-1:0] p_o
);

  logic [33:0] z1;
  logic [33:0] mid;

  always_comb begin
    // Restore the 17x17 middle product from the 16x16 product of the sum low halves.
    z1 = {2'b00, pm_i};
    if (sa_i[HALF_W]) z1 = z1 + {2'b00, sb_i[HALF_W-1:0], 16'h0000};
    if (sb_i[HALF_W]) z1 = z1 + {2'b00, sa_i[HALF_W-1:0], 16'h0000};
    if (sa_i[HALF_W] & sb_i[HALF_W]) z1 = z1 + 34'h1_0000_0000;

    mid = z1 - {2'b00, z2_i} - {2'b00, z0_i};

    // Summing modulo 2^64 equals truncating the exact 66-bit sum.
    p_o = {z2_i, 32'h0000_0000} + {14'h0000, mid, 16'h0000} + {32'h0000_0000, z0_i};
  end

endmodule

// File: rtl/karatsuba32_seq.sv
// 32x32 -> 64 unsigned multiplier issuing three 16x16 products to an external mult16.
module karatsuba32_seq
  import karatsuba_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  karatsuba32_seq_if.slave  host,
  mult16_if.master          mul
);

  kseq_state_t         state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [FULL_W-1:0]   a_q, a_d, b_q, b_d;
  logic [HALF_W:0]     sa_q, sa_d, sb_q, sb_d;
  logic [HALF_W:0]     sa_in, sb_in;
  logic [FULL_W-1:0]   z0_q, z0_d, z2_q, z2_d, pm_q, pm_d;
  logic [PROD_W-1:0]   p_q, p_d, comb_p;
  logic                done_q, done_d;
  logic                m_start_q, m_start_d;
  logic [HALF_W-1:0]   m_a_q, m_a_d, m_b_q, m_b_d;

  assign sa_in = {1'b0, host.A[HALF_W-1:0]} + {1'b0, host.A[FULL_W-1:HALF_W]};
  assign sb_in = {1'b0, host.B[HALF_W-1:0]} + {1'b0, host.B[FULL_W-1:HALF_W]};

  karatsuba_combine u_combine (
    .z0_i (z0_q),
    .z2_i (z2_q),
    .pm_i (pm_q),
    .sa_i (sa_q),
    .sb_i (sb_q),
    .p_o  (comb_p)
  );

  // NOTE: every *_d defaults to its *_q first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    a_d       = a_q;
    b_d       = b_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    z0_d      = z0_q;
    z2_d      = z2_q;
    pm_d      = pm_q;
    p_d       = p_q;
    done_d    = done_q;
    m_start_d = m_start_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;

    case (state_q)
      IDLE: begin
        if (host.start) begin
          a_d              = host.A;
          b_d              = host.B;
          sa_d             = sa_in;
          sb_d             = sb_in;
          phase_d          = PH_LO;
          m_start_d        = 1'b1;
          {m_a_d, m_b_d}   = phase_operands(PH_LO, host.A, host.B,
                                            sa_in[HALF_W-1:0], sb_in[HALF_W-1:0]);
          state_d          = REQ;
        end
      end
      REQ: begin
        if (mul.m_done) begin
          case (phase_q)
            PH_LO:   z0_d = mul.m_p;
            PH_HI:   z2_d = mul.m_p;
            default: pm_d = mul.m_p;
          endcase
          m_start_d = 1'b0;
          state_d   = REL;
        end
      end
      REL: begin
        // Waiting for m_done low keeps m_start from rising into a stale done.
        if (!mul.m_done) begin
          if (phase_q != PH_MID) begin
            phase_d        = phase_q + 2'd1;
            m_start_d      = 1'b1;
            {m_a_d, m_b_d} = phase_operands(phase_q + 2'd1, a_q, b_q,
                                            sa_q[HALF_W-1:0], sb_q[HALF_W-1:0]);
            state_d        = REQ;
          end else begin
            state_d = COMB;
          end
        end
      end
      COMB: begin
        p_d     = comb_p;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!host.start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers reset together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_LO;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      z0_q      <= '0;
      z2_q      <= '0;
      pm_q      <= '0;
      p_q       <= '0;
      done_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      z0_q      <= z0_d;
      z2_q      <= z2_d;
      pm_q      <= pm_d;
      p_q       <= p_d;
      done_q    <= done_d;
      m_start_q <= m_start_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
    end
  end

  assign host.done   = done_q;
  assign host.P      = p_q;
  assign mul.m_start = m_start_q;
  assign mul.m_a     = m_a_q;
  assign mul.m_b     = m_b_q;

endmodule

// File: tb/tb_karatsuba32_seq.sv
// Bench for karatsuba32_seq with a behavioural mult16 partner and a plain a*b reference.
module tb_karatsuba32_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   viol_cnt = 0;
  logic ms_prev = 1'b0;

  karatsuba32_seq_if host_if ();
  mult16_if          mul_if ();

  karatsuba32_seq dut (
    .clk  (clk),
    .rst  (rst),
    .host (host_if),
    .mul  (mul_if)
  );

  always #5 clk = ~clk;

  // mult16 partner: done one edge after start, held until start drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_if.m_done <= 1'b0;
      mul_if.m_p    <= '0;
    end else if (!mul_if.m_done && mul_if.m_start) begin
      mul_if.m_p    <= 32'(mul_if.m_a) * 32'(mul_if.m_b);
      mul_if.m_done <= 1'b1;
    end else if (mul_if.m_done && !mul_if.m_start) begin
      mul_if.m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mul_if.m_start && !ms_prev && mul_if.m_done) viol_cnt++;
    ms_prev = mul_if.m_start;
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Drives a request and returns once done is seen (or the cycle budget runs out).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int drop_at, output int lat);
    @(negedge clk);
    host_if.A = a;
    host_if.B = b;
    host_if.start = 1'b1;
    @(posedge clk);
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (host_if.done) break;
      if (lat >= 60) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no done after %0d edges, expected at 13", lat);
        break;
      end
      if (lat == drop_at) begin
        @(negedge clk);
        host_if.start = 1'b0;
      end
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    host_if.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (host_if.done !== 1'b0 || host_if.P !== 64'd0 || mul_if.m_start !== 1'b0 ||
        mul_if.m_a !== 16'd0 || mul_if.m_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: done=%b P=%h m_start=%b m_a=%h m_b=%h, expected all zero",
               host_if.done, host_if.P, mul_if.m_start, mul_if.m_a, mul_if.m_b);
    end
  endtask

  task automatic test_directed();
    logic [31:0] av [4] = '{32'h12345678, 32'hFFFFFFFF, 32'h00010000, 32'h00000000};
    logic [31:0] bv [4] = '{32'h9ABCDEF0, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF};
    logic [63:0] pv [4] = '{64'h0B00EA4E242D2080, 64'hFFFFFFFE00000001,
                            64'h0000000100000000, 64'h0000000000000000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], -1, lat);
      checks++;
      if (host_if.P !== pv[i]) begin
        errors++;
        $display("FAIL directed_p[%0d]: got %h, expected %h", i, host_if.P, pv[i]);
      end
      checks++;
      if (lat !== 13) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges, expected 13", i, lat);
      end
      release_start();
      checks++;
      if (host_if.done !== 1'b0) begin
        errors++;
        $display("FAIL directed_clear[%0d]: done=%b, expected 0", i, host_if.done);
      end
    end
  endtask

  task automatic test_hold_and_back_to_back();
    int lat;
    logic [63:0] exp_p;
    exp_p = model(32'hDEADBEEF, 32'h0BADF00D);
    run_op(32'hDEADBEEF, 32'h0BADF00D, -1, lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (host_if.done !== 1'b1 || host_if.P !== exp_p) begin
        errors++;
        $display("FAIL hold_stable[%0d]: done=%b P=%h, expected done=1 P=%h",
                 i, host_if.done, host_if.P, exp_p);
      end
    end
    release_start();
    checks++;
    if (host_if.done !== 1'b0) begin
      errors++;
      $display("FAIL hold_clear: done=%b, expected 0", host_if.done);
    end
    run_op(32'd3, 32'd5, -1, lat);
    checks++;
    if (host_if.P !== 64'd15 || lat !== 13) begin
      errors++;
      $display("FAIL back_to_back: P=%0d lat=%0d, expected P=15 lat=13", host_if.P, lat);
    end
    release_start();
  endtask

  task automatic test_drop_mid();
    int lat;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    run_op(a, b, 5, lat);
    checks++;
    if (host_if.P !== model(a, b) || lat !== 13) begin
      errors++;
      $display("FAIL drop_mid_result: P=%h lat=%0d, expected P=%h lat=13",
               host_if.P, lat, model(a, b));
    end
    @(posedge clk);
    #1;
    checks++;
    if (host_if.done !== 1'b0) begin
      errors++;
      $display("FAIL drop_mid_one_cycle: done=%b, expected 0", host_if.done);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    host_if.A = 32'h12345678;
    host_if.B = 32'h9ABCDEF0;
    host_if.start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    host_if.start = 1'b0;
    #1;
    checks++;
    if (host_if.done !== 1'b0 || host_if.P !== 64'd0 || mul_if.m_start !== 1'b0 ||
        mul_if.m_a !== 16'd0 || mul_if.m_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: done=%b P=%h m_start=%b m_a=%h m_b=%h, expected all zero",
               host_if.done, host_if.P, mul_if.m_start, mul_if.m_a, mul_if.m_b);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd7, 32'd9, -1, lat);
    checks++;
    if (host_if.P !== 64'd63 || lat !== 13) begin
      errors++;
      $display("FAIL after_reset: P=%0d lat=%0d, expected P=63 lat=13", host_if.P, lat);
    end
    release_start();
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = a | 32'h80008000;
      if (i % 4 == 2) b = b | 32'hC000C000;
      run_op(a, b, -1, lat);
      checks++;
      if (host_if.P !== model(a, b)) begin
        errors++;
        $display("FAIL random_p[%0d]: A=%h B=%h got %h, expected %h",
                 i, a, b, host_if.P, model(a, b));
      end
      checks++;
      if (lat !== 13) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d, expected 13", i, lat);
      end
      release_start();
    end
  endtask

  task automatic test_handshake_guard();
    checks++;
    if (viol_cnt !== 0) begin
      errors++;
      $display("FAIL m_start_rise_guard: %0d rises while m_done high, expected 0", viol_cnt);
    end
  endtask

  initial begin
    host_if.start = 1'b0;
    host_if.A = '0;
    host_if.B = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_hold_and_back_to_back();
    test_drop_mid();
    test_reset_mid();
    test_random();
    test_handshake_guard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/karatsuba32_seq.md
# karatsuba32_seq

Sequencer that computes a 32x32 -> 64-bit unsigned product by the Karatsuba method, issuing three 16x16 products to an external `mult16` over its start/done handshake and combining the partial products. It sits directly upstream of `mult16`: it drives `mult16`'s operands and start, and consumes its product and done. It exposes the same level-held start/done handshake to its own requester.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit product.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; level-held by the requester until `done` is seen.
- `A`, `B`  in  32 each  unsigned operands, sampled on the accepting edge only.
- `done`  out  1  high while the result is valid; held until `start` drops.
- `P`  out  64  unsigned product; stable while `done` is high.
- `m_start`  out  1  start to `mult16`.
- `m_a`, `m_b`  out  16 each  `mult16` operands; stable while `m_start` is high.
- `m_done`  in  1  done from `mult16`.
- `m_p`  in  32  product from `mult16`.

## Operation
- Split the operands: AL=A[15:0], AH=A[31:16], BL=B[15:0], BH=B[31:16]. Compute sa=AL+AH and sb=BL+BH, each 17 bits.
- Issue three phases in fixed order:
  - ph0: z0=AL*BL.
  - ph1: z2=AH*BH.
  - ph2: pm=sa[15:0]*sb[15:0].
- Correct the 17x17 middle product to 34 bits: z1 = pm + (sa[16] ? sb[15:0]<<16 : 0) + (sb[16] ? sa[15:0]<<16 : 0) + (sa[16]&sb[16] ? 1<<32 : 0).
- mid = z1 - z2 - z0, computed in 34 bits; the result is never negative and fits in 33 bits.
- P = (z2<<32) + (mid<<16) + z0, computed in 66 bits internally and truncated to 64. This truncation is lossless.
- FSM states: IDLE, REQ, REL, COMB, DONE, plus a 2-bit phase counter (0..2).
  - IDLE: on start=1, latch A and B and the derived halves and sums, set phase=0, go to REQ.
  - REQ: m_start=1 with the phase's operands. On m_done=1, capture m_p into z0, z2 or pm; drop m_start; go to REL.
  - REL: m_start=0. On m_done=0, if phase<2 then increment phase and go to REQ; else go to COMB.
  - COMB: register P from the formula above; set done=1; go to DONE.
  - DONE: hold P and done. On start=0, clear done and go to IDLE.
- `start` dropping before completion is ignored. The computation finishes, `done` is asserted for exactly one cycle, and then clears.
- A new request is accepted only from IDLE, so `start` must be seen low after `done` before the next request. This mirrors the `mult16` rule.
- `m_start` never rises while `m_done` is high. This guarantees `mult16` observes a fresh start edge on every phase.

## Timing
- Reset values: done=0, P=0, m_start=0, m_a=0, m_b=0, state=IDLE, phase=0, and all internal partial-product registers 0.
- Reset mid-operation: everything returns to the reset values immediately. `mult16` shares `rst`, so no stale handshake survives.
- All outputs are registered.
- Per-phase cost with `mult16`: 4 cycles.
  - Edge e: REQ entered, m_start=1.
  - e+1: m_done=1.
  - e+2: capture, m_start=0.
  - e+3: m_done=0.
  - e+4: next REQ, or COMB after ph2.
- Latency: start sampled high at edge N (IDLE) gives done=1 and P valid after edge N+13.
- Clearing: start=0 sampled at edge M while in DONE gives done=0 after edge M.
- Earliest re-accept: edge M+1. The FSM waits on the handshake levels, not on fixed counts.

## Structure
- Package `karatsuba_pkg`:
  - state enum `kseq_state_t` (IDLE, REQ, REL, COMB, DONE).
  - phase constants PH_LO=0, PH_HI=1, PH_MID=2.
  - width constants HALF_W=16, FULL_W=32, PROD_W=64.
- Sub-module `karatsuba_combine`: purely combinational. It takes z0, z2, pm, sa and sb, applies the correction, and produces the 64-bit P. The FSM registers its output in COMB.
- `mult16` is instantiated beside this block at the next level up, not inside it.

## Test plan
- A=0x12345678, B=0x9ABCDEF0 -> P=0x0B00EA4E242D2080. done rises exactly 13 edges after start is accepted.
- A=B=0xFFFFFFFF exercises sa[16]&sb[16] and the full correction -> P=0xFFFFFFFE00000001.
- A=B=0x00010000 -> P=0x0000000100000000. A=0, B=0xFFFFFFFF -> P=0.
- Hold start after done: done and P stay stable for 20 cycles. Drop start: done=0 one edge later. Back-to-back request with A=3, B=5 -> P=15.
- Drop start during ph1: done=1 for one cycle after edge N+13, then 0. Assert no m_start rise while m_done=1 at any point.
- Assert rst during ph2: all outputs return to 0 immediately. A fresh request A=7, B=9 -> P=63 with the normal 13-edge latency.
